// File: rtl/key_event_decoder_if.sv
// Key sample stream and decoded event pulses between the debouncer side and the decoder.
//   key_value, key_valid, clear : sample stream and abort, driven by master
//   key_state                   : registered pressed level, driven by slave
//   short_press .. long_release : one-cycle event pulses, driven by slave
interface key_event_decoder_if;
    logic key_value;
    logic key_valid;
    logic clear;
    logic key_state;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_press;
    logic long_release;

    modport master (
        output key_value, key_valid, clear,
        input  key_state, short_press, double_press, long_press, repeat_press, long_release
    );

    modport slave (
        input  key_value, key_valid, clear,
        output key_state, short_press, double_press, long_press, repeat_press, long_release
    );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key samples into short/double/long/repeat/long-release pulses.
// All timing is counted in valid samples (ticks), not clk cycles.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of key_event_decoder_if (samples in, registered events out)
module key_event_decoder #(
    parameter logic        ACTIVE_LEVEL = 1'b0,
    parameter int unsigned LONG_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10,
    parameter int unsigned DCLICK_TICKS = 15
) (
    input logic               clk,
    input logic               rstn,
    key_event_decoder_if.slave bus
);

    localparam int unsigned MAX_LR    = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_LR > DCLICK_TICKS) ? MAX_LR : DCLICK_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);

    // Terminal counts; zero-tick settings are guarded at the use site.
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
    localparam logic [CW-1:0] DCLICK_LAST = CW'((DCLICK_TICKS == 0) ? 0 : DCLICK_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          key_state_q, key_state_nxt;
    logic          short_q, double_q, long_q, repeat_q, release_q;
    logic          short_nxt, double_nxt, long_nxt, repeat_nxt, release_nxt;
    logic          p;

    assign p = (bus.key_value == ACTIVE_LEVEL);

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            key_state_q <= 1'b0;
            short_q     <= 1'b0;
            double_q    <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_state_q <= key_state_nxt;
            short_q     <= short_nxt;
            double_q    <= double_nxt;
            long_q      <= long_nxt;
            repeat_q    <= repeat_nxt;
            release_q   <= release_nxt;
        end
    end

    // Next state and event decode; clear wins over a coincident sample.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        key_state_nxt = key_state_q;
        short_nxt     = 1'b0;
        double_nxt    = 1'b0;
        long_nxt      = 1'b0;
        repeat_nxt    = 1'b0;
        release_nxt   = 1'b0;

        if (bus.clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (bus.key_valid) begin
            key_state_nxt = p;
            case (state)
                IDLE: begin
                    if (p) begin
                        state_nxt = PRESS1;
                        cnt_nxt   = CW'(1);
                    end
                end
                PRESS1: begin
                    if (p) begin
                        if (cnt == LONG_LAST) begin
                            long_nxt  = 1'b1;
                            state_nxt = LONG;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else if (DCLICK_TICKS == 0) begin
                        short_nxt = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = CW'(1);
                    end
                end
                GAP: begin
                    if (p) begin
                        state_nxt = PRESS2;
                        cnt_nxt   = '0;
                    end else if (cnt >= DCLICK_LAST) begin
                        short_nxt = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                PRESS2: begin
                    if (!p) begin
                        double_nxt = 1'b1;
                        state_nxt  = IDLE;
                        cnt_nxt    = '0;
                    end
                end
                LONG: begin
                    if (!p) begin
                        release_nxt = 1'b1;
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                    end else if ((REPEAT_TICKS != 0) && (cnt == REPEAT_LAST)) begin
                        repeat_nxt = 1'b1;
                        cnt_nxt    = '0;
                    end else if (cnt != '1) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.key_state    = key_state_q;
    assign bus.short_press  = short_q;
    assign bus.double_press = double_q;
    assign bus.long_press   = long_q;
    assign bus.repeat_press = repeat_q;
    assign bus.long_release = release_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench: dut_a uses DCLICK_TICKS=3, dut_b uses DCLICK_TICKS=0; both see the same samples.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rstn;
    logic key_value;
    logic key_valid;
    logic clear;

    int tests = 0;
    int fails = 0;

    // Event vector bit order: short, double, long, repeat, long_release.
    localparam logic [4:0] EV_NONE = 5'b00000;
    localparam logic [4:0] EV_SHRT = 5'b10000;
    localparam logic [4:0] EV_DBL  = 5'b01000;
    localparam logic [4:0] EV_LONG = 5'b00100;
    localparam logic [4:0] EV_REP  = 5'b00010;
    localparam logic [4:0] EV_REL  = 5'b00001;

    localparam logic P = 1'b0;
    localparam logic R = 1'b1;

    key_event_decoder_if bus_a ();
    key_event_decoder_if bus_b ();

    assign bus_a.key_value = key_value;
    assign bus_a.key_valid = key_valid;
    assign bus_a.clear     = clear;
    assign bus_b.key_value = key_value;
    assign bus_b.key_valid = key_valid;
    assign bus_b.clear     = clear;

    key_event_decoder #(
        .ACTIVE_LEVEL (1'b0),
        .LONG_TICKS   (4),
        .REPEAT_TICKS (2),
        .DCLICK_TICKS (3)
    ) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a.slave)
    );

    key_event_decoder #(
        .ACTIVE_LEVEL (1'b0),
        .LONG_TICKS   (4),
        .REPEAT_TICKS (2),
        .DCLICK_TICKS (0)
    ) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b.slave)
    );

    always #5 clk = ~clk;

    logic [4:0] ev_a, ev_b;
    assign ev_a = {bus_a.short_press, bus_a.double_press, bus_a.long_press,
                   bus_a.repeat_press, bus_a.long_release};
    assign ev_b = {bus_b.short_press, bus_b.double_press, bus_b.long_press,
                   bus_b.repeat_press, bus_b.long_release};

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One valid sample at a negedge; check events/key_state one clk later, then check the pulse drops.
    task automatic step_a(input string tag, input logic v, input logic [4:0] exp_ev);
        @(negedge clk);
        key_value = v;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check({tag, ".ev"}, ev_a, exp_ev);
        check({tag, ".ks"}, {4'b0, bus_a.key_state}, {4'b0, (v == P)});
        @(negedge clk);
        check({tag, ".drop"}, ev_a, EV_NONE);
    endtask

    task automatic step_b(input string tag, input logic v, input logic [4:0] exp_ev);
        @(negedge clk);
        key_value = v;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check({tag, ".ev"}, ev_b, exp_ev);
        @(negedge clk);
        check({tag, ".drop"}, ev_b, EV_NONE);
    endtask

    initial begin
        rstn      = 1'b0;
        key_value = 1'b1;
        key_valid = 1'b0;
        clear     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.ev_a", ev_a, EV_NONE);
        check("rst.ev_b", ev_b, EV_NONE);
        check("rst.ks", {4'b0, bus_a.key_state}, 5'b0);
        rstn = 1'b1;

        // 1: toggling value without valid does nothing
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key_value = ~key_value;
            @(negedge clk);
            check("t1.ev", ev_a, EV_NONE);
            check("t1.ks", {4'b0, bus_a.key_state}, 5'b0);
        end
        key_value = R;

        // 2: short press after the third released sample
        step_a("t2.p1", P, EV_NONE);
        step_a("t2.p2", P, EV_NONE);
        step_a("t2.r1", R, EV_NONE);
        step_a("t2.r2", R, EV_NONE);
        step_a("t2.r3", R, EV_SHRT);

        // 3: double press
        step_a("t3.p1", P, EV_NONE);
        step_a("t3.r1", R, EV_NONE);
        step_a("t3.p2", P, EV_NONE);
        step_a("t3.r2", R, EV_DBL);

        // 4: long press, repeats, long release
        step_a("t4.p1", P, EV_NONE);
        step_a("t4.p2", P, EV_NONE);
        step_a("t4.p3", P, EV_NONE);
        step_a("t4.p4", P, EV_LONG);
        step_a("t4.p5", P, EV_NONE);
        step_a("t4.p6", P, EV_REP);
        step_a("t4.p7", P, EV_NONE);
        step_a("t4.p8", P, EV_REP);
        step_a("t4.r",  R, EV_REL);

        // 5: clear mid-long-press discards the sample and any pending release
        step_a("t5.p1", P, EV_NONE);
        step_a("t5.p2", P, EV_NONE);
        step_a("t5.p3", P, EV_NONE);
        step_a("t5.p4", P, EV_LONG);
        step_a("t5.p5", P, EV_NONE);
        @(negedge clk);
        key_value = P;
        key_valid = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        clear     = 1'b0;
        check("t5.clr.ev", ev_a, EV_NONE);
        check("t5.clr.ks", {4'b0, bus_a.key_state}, 5'b00001);
        check("t5.clr.ev_b", ev_b, EV_NONE);
        step_a("t5.r", R, EV_NONE);

        // 6: double-click disabled build
        step_b("t6.p1", P, EV_NONE);
        step_b("t6.r1", R, EV_SHRT);
        step_b("t6.p2", P, EV_NONE);
        step_b("t6.r2", R, EV_SHRT);
        step_b("t6.p3", P, EV_NONE);
        step_b("t6.r3", R, EV_SHRT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
